// File: rtl/pc_unit.sv
// pc_unit: program-counter unit between execute and instruction fetch.
// Holds the architectural PC and applies trap, trap-return, jump and
// taken-branch redirects in that order of priority. A misaligned jump or
// branch target is turned into a trap. The PC is offered to fetch with a
// valid/ready handshake, and a one-cycle bubble follows every redirect.
module pc_unit #(
    parameter int PC_WIDTH     = 12,
    parameter int OPD_WIDTH    = 32,
    parameter int INSTR_BYTES  = 4,
    parameter int RESET_VECTOR = 0,
    parameter int TRAP_VECTOR  = 'h100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 branch,
    input  logic [OPD_WIDTH-1:0] comp_result,
    input  logic                 jump,
    input  logic [OPD_WIDTH-1:0] target,
    input  logic                 trap,
    input  logic                 mret,
    input  logic                 fetch_ready,
    output logic                 fetch_valid,
    output logic [PC_WIDTH-1:0]  pc_out,
    output logic [PC_WIDTH-1:0]  pc_seq,
    output logic [PC_WIDTH-1:0]  epc,
    output logic                 in_trap,
    output logic                 misaligned
);

    localparam logic [PC_WIDTH-1:0] INC        = PC_WIDTH'(INSTR_BYTES);
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = INC - 1'b1;
    localparam logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(RESET_VECTOR);
    localparam logic [PC_WIDTH-1:0] TRAP_PC    = PC_WIDTH'(TRAP_VECTOR);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        BUBBLE
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] pcSeq_q;
    logic [PC_WIDTH-1:0] epc_q, epc_d;
    logic                inTrap_q, inTrap_d;
    logic                misaligned_q, misaligned_d;
    logic                fetchValid_q;

    logic [PC_WIDTH-1:0] targetPc;
    logic                takenBranch;
    logic                targetMisaligned;
    logic                canAdvance;

    // Upper target bits beyond the PC width are intentionally discarded.
    logic                unusedTargetBits;
    assign unusedTargetBits = ^target;

    assign targetPc         = target[PC_WIDTH-1:0];
    assign takenBranch      = jump | (branch & (comp_result == OPD_WIDTH'(1)));
    assign targetMisaligned = |(targetPc & ALIGN_MASK);
    assign canAdvance       = (state_q == RUN) & fetchValid_q & fetch_ready & ~stall;

    // Next-state selection: redirect priority, then sequential advance or hold.
    always_comb begin
        pc_d         = pc_q;
        epc_d        = epc_q;
        inTrap_d     = inTrap_q;
        misaligned_d = 1'b0;
        state_d      = RUN;
        if (trap) begin
            pc_d     = TRAP_PC;
            epc_d    = pc_q;
            inTrap_d = 1'b1;
            state_d  = BUBBLE;
        end else if (mret && inTrap_q) begin
            pc_d     = epc_q;
            inTrap_d = 1'b0;
            state_d  = BUBBLE;
        end else if (takenBranch) begin
            if (targetMisaligned) begin
                pc_d         = TRAP_PC;
                epc_d        = pc_q;
                inTrap_d     = 1'b1;
                misaligned_d = 1'b1;
            end else begin
                pc_d = targetPc;
            end
            state_d = BUBBLE;
        end else if (canAdvance) begin
            pc_d = pc_q + INC;
        end
    end

    // State and registered outputs; the link address is derived from the next PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            pcSeq_q      <= RESET_PC + INC;
            epc_q        <= '0;
            inTrap_q     <= 1'b0;
            misaligned_q <= 1'b0;
            fetchValid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pcSeq_q      <= pc_d + INC;
            epc_q        <= epc_d;
            inTrap_q     <= inTrap_d;
            misaligned_q <= misaligned_d;
            fetchValid_q <= (state_d == RUN);
        end
    end

    assign fetch_valid = fetchValid_q;
    assign pc_out      = pc_q;
    assign pc_seq      = pcSeq_q;
    assign epc         = epc_q;
    assign in_trap     = inTrap_q;
    assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed and randomized checks of pc_unit against a
// behavioural model of the PC, trap and fetch-handshake rules.
module tb_pc_unit;

    localparam int PW = 12;
    localparam int OW = 32;

    logic          clk = 1'b0;
    logic          rst, stall, branch, jump, trap, mret, fetch_ready;
    logic [OW-1:0] comp_result, target;
    logic          fetch_valid, in_trap, misaligned;
    logic [PW-1:0] pc_out, pc_seq, epc;

    int vectors = 0;
    int miscompares = 0;
    bit checkEn = 0;

    // Behavioural model state
    logic [PW-1:0] mPc, mEpc;
    logic          mInTrap, mMis, mValid;

    pc_unit #(
        .PC_WIDTH(PW), .OPD_WIDTH(OW), .INSTR_BYTES(4),
        .RESET_VECTOR(0), .TRAP_VECTOR('h100)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch(branch),
        .comp_result(comp_result), .jump(jump), .target(target),
        .trap(trap), .mret(mret), .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid), .pc_out(pc_out), .pc_seq(pc_seq),
        .epc(epc), .in_trap(in_trap), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock edge of the architectural rules, using the inputs held at the edge.
    task automatic modelStep();
        bit redirect;
        bit taken;
        logic [PW-1:0] tgt;
        if (rst) begin
            mPc = '0; mEpc = '0; mInTrap = 0; mMis = 0; mValid = 0;
            return;
        end
        redirect = 1;
        mMis = 0;
        tgt = target[PW-1:0];
        taken = jump || (branch && comp_result == 1);
        if (trap) begin
            mEpc = mPc; mPc = 'h100; mInTrap = 1;
        end else if (mret && mInTrap) begin
            mPc = mEpc; mInTrap = 0;
        end else if (taken && (tgt % 4) != 0) begin
            mEpc = mPc; mPc = 'h100; mInTrap = 1; mMis = 1;
        end else if (taken) begin
            mPc = tgt;
        end else begin
            redirect = 0;
            if (mValid && fetch_ready && !stall) mPc = mPc + 4;
        end
        mValid = !redirect;
    endtask

    task automatic applyStimulus(input bit r, input bit st, input bit br, input logic [OW-1:0] cr,
                                 input bit j, input logic [OW-1:0] tg, input bit tr, input bit mr,
                                 input bit rdy);
        rst = r; stall = st; branch = br; comp_result = cr; jump = j;
        target = tg; trap = tr; mret = mr; fetch_ready = rdy;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic idle(input bit rdy);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, rdy);
    endtask

    task automatic doJump(input logic [OW-1:0] tg);
        applyStimulus(0, 0, 0, 0, 1, tg, 0, 0, 1);
    endtask

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("pc_out", 32'(pc_out), 32'(mPc));
            checkOutput("pc_seq", 32'(pc_seq), 32'(PW'(mPc + 4)));
            checkOutput("fetch_valid", 32'(fetch_valid), 32'(mValid));
            checkOutput("epc", 32'(epc), 32'(mEpc));
            checkOutput("in_trap", 32'(in_trap), 32'(mInTrap));
            checkOutput("misaligned", 32'(misaligned), 32'(mMis));
        end
    end

    initial begin
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1);
        checkEn = 1;
        checkOutput("lit_reset_pc", 32'(pc_out), 32'h0);
        checkOutput("lit_reset_seq", 32'(pc_seq), 32'h4);
        checkOutput("lit_reset_valid", 32'(fetch_valid), 32'h0);

        // Reset release: 0,0,4,8 with valid 0,1,1,1
        idle(1);
        checkOutput("lit_rel1_pc", 32'(pc_out), 32'h0);
        checkOutput("lit_rel1_valid", 32'(fetch_valid), 32'h1);
        idle(1);
        checkOutput("lit_rel2_pc", 32'(pc_out), 32'h4);
        idle(1);
        checkOutput("lit_rel3_pc", 32'(pc_out), 32'h8);

        // Jump with bubble
        doJump(32'h40);
        checkOutput("lit_jmp_pc", 32'(pc_out), 32'h40);
        checkOutput("lit_jmp_bubble", 32'(fetch_valid), 32'h0);
        idle(1);
        idle(1);
        checkOutput("lit_jmp_next", 32'(pc_out), 32'h44);

        // Branch with comp_result=2 not taken, then misaligned taken branch
        doJump(32'hC);
        idle(1);
        idle(1);
        applyStimulus(0, 0, 1, 2, 0, 32'h80, 0, 0, 1);
        checkOutput("lit_br2_pc", 32'(pc_out), 32'h14);
        applyStimulus(0, 0, 1, 1, 0, 32'hFF, 0, 0, 1);
        checkOutput("lit_mis_pulse", 32'(misaligned), 32'h1);
        checkOutput("lit_mis_pc", 32'(pc_out), 32'h100);
        checkOutput("lit_mis_epc", 32'(epc), 32'h14);
        checkOutput("lit_mis_trap", 32'(in_trap), 32'h1);
        idle(1);
        checkOutput("lit_mis_clear", 32'(misaligned), 32'h0);

        // Trap beats jump; mret returns; second mret ignored
        doJump(32'h20);
        idle(1);
        applyStimulus(0, 0, 0, 0, 1, 32'h80, 1, 0, 1);
        checkOutput("lit_trap_pc", 32'(pc_out), 32'h100);
        checkOutput("lit_trap_epc", 32'(epc), 32'h20);
        idle(1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
        checkOutput("lit_mret_pc", 32'(pc_out), 32'h20);
        checkOutput("lit_mret_trap", 32'(in_trap), 32'h0);
        idle(1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
        checkOutput("lit_mret2_pc", 32'(pc_out), 32'h24);
        checkOutput("lit_mret2_valid", 32'(fetch_valid), 32'h1);

        // Stall holds PC; jump during stall is taken; fetch_ready=0 holds
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("lit_stall_pc", 32'(pc_out), 32'h24);
        applyStimulus(0, 1, 0, 0, 1, 32'h200, 0, 0, 1);
        checkOutput("lit_stall_jmp", 32'(pc_out), 32'h200);
        idle(0);
        idle(0);
        checkOutput("lit_nordy_pc", 32'(pc_out), 32'h200);
        checkOutput("lit_nordy_valid", 32'(fetch_valid), 32'h1);

        // Wrap-around
        doJump(32'hFFC);
        idle(1);
        idle(1);
        checkOutput("lit_wrap_pc", 32'(pc_out), 32'h0);
        checkOutput("lit_wrap_seq", 32'(pc_seq), 32'h4);

        // Reset while trapped and in a bubble
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 32'h300, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 1, 32'h300, 1, 0, 1);
        checkOutput("lit_rst_pc", 32'(pc_out), 32'h0);
        checkOutput("lit_rst_epc", 32'(epc), 32'h0);
        checkOutput("lit_rst_trap", 32'(in_trap), 32'h0);
        checkOutput("lit_rst_valid", 32'(fetch_valid), 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [OW-1:0] tg;
            logic [OW-1:0] cr;
            tg = $urandom();
            if ($urandom_range(3) != 0) tg[1:0] = 2'b00;
            if ($urandom_range(9) == 0) tg[PW-1:0] = PW'('hFF8 + 4 * $urandom_range(1));
            case ($urandom_range(3))
                0: cr = 0;
                1: cr = 1;
                2: cr = 2;
                default: cr = $urandom();
            endcase
            applyStimulus($urandom_range(99) == 0, $urandom_range(5) == 0,
                          $urandom_range(4) == 0, cr, $urandom_range(7) == 0, tg,
                          $urandom_range(19) == 0, $urandom_range(9) == 0,
                          $urandom_range(3) != 0);
        end

        checkEn = 0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
